// File: rtl/mem_ctrl_if.sv
// Requester and RAM port bundle for mem_ctrl: IF fetch, MEM load/store, byte-wide RAM.
interface mem_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [31:0]       if_data;

  logic              mem_req;
  logic              mem_write;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  logic              stall_mem;
  logic              stall_if;

  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_dout;
  logic              ram_wr;
  logic [7:0]        ram_din;

  // Controller side
  modport slave (
    input  if_req, if_addr, mem_req, mem_write, mem_size, mem_addr, mem_wdata, ram_din,
    output if_ready, if_data, mem_ready, mem_rdata, stall_mem, stall_if,
           ram_addr, ram_dout, ram_wr
  );

  // Requester / RAM side
  modport master (
    output if_req, if_addr, mem_req, mem_write, mem_size, mem_addr, mem_wdata, ram_din,
    input  if_ready, if_data, mem_ready, mem_rdata, stall_mem, stall_if,
           ram_addr, ram_dout, ram_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial RAM port owner: arbitrates IF/MEM (MEM first) and assembles or splits
// 1/2/4-byte accesses little-endian, pulsing the requester's ready once per access.
module mem_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input logic       clock,
  input logic       reset,
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        len_q, len_d;
  logic              src_mem_q, src_mem_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;
  logic              if_ready_q, if_ready_d;
  logic              mem_ready_q, mem_ready_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic [2:0]        next_cnt;
  logic [1:0]        rd_lane;
  logic [1:0]        wr_lane;

  // State and registered outputs; reset aborts any access in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      src_mem_q   <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      ram_addr_q  <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      src_mem_q   <= src_mem_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
    end
  end

  // Next state and next values of the registered RAM/requester outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    src_mem_d   = src_mem_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    ram_addr_d  = '0;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = 1'b0;
    next_cnt    = cnt_q + 3'd1;
    rd_lane     = 2'(cnt_q - 3'd1);
    wr_lane     = 2'(next_cnt);

    unique case (state_q)
      IDLE: begin
        if (bus.mem_req) begin
          src_mem_d  = 1'b1;
          base_d     = bus.mem_addr;
          wdata_d    = bus.mem_wdata;
          rbuf_d     = '0;
          cnt_d      = '0;
          len_d      = (bus.mem_size == 2'b00) ? 3'd1 :
                       (bus.mem_size == 2'b01) ? 3'd2 : 3'd4;
          ram_addr_d = bus.mem_addr;
          if (bus.mem_write) begin
            state_d    = WRITE;
            ram_wr_d   = 1'b1;
            ram_dout_d = bus.mem_wdata[7:0];
          end else begin
            state_d = READ;
          end
        end else if (bus.if_req) begin
          src_mem_d  = 1'b0;
          base_d     = bus.if_addr;
          rbuf_d     = '0;
          cnt_d      = '0;
          len_d      = 3'd4;
          ram_addr_d = bus.if_addr;
          state_d    = READ;
        end
      end

      READ: begin
        // ram_din carries the byte addressed one cycle earlier
        if (cnt_q != 3'd0) begin
          rbuf_d[{rd_lane, 3'b000} +: 8] = bus.ram_din;
        end
        if (cnt_q == len_q) begin
          state_d = DONE;
          if (src_mem_q) begin
            mem_ready_d = 1'b1;
            mem_rdata_d = rbuf_d;
          end else begin
            if_ready_d = 1'b1;
            if_data_d  = rbuf_d;
          end
        end else begin
          cnt_d = next_cnt;
          if (next_cnt < len_q) begin
            ram_addr_d = base_q + ADDR_W'(next_cnt);
          end
        end
      end

      WRITE: begin
        if (next_cnt < len_q) begin
          cnt_d      = next_cnt;
          ram_wr_d   = 1'b1;
          ram_addr_d = base_q + ADDR_W'(next_cnt);
          ram_dout_d = wdata_q[{wr_lane, 3'b000} +: 8];
        end else begin
          state_d     = DONE;
          mem_ready_d = 1'b1;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign bus.if_ready  = if_ready_q;
  assign bus.if_data   = if_data_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_dout  = ram_dout_q;
  assign bus.ram_wr    = ram_wr_q;
  assign bus.stall_mem = bus.mem_req & ~mem_ready_q;
  assign bus.stall_if  = bus.if_req & ~if_ready_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide RAM model (read data one cycle after address).
module tb_mem_ctrl;
  logic clock;
  logic reset;
  int   errors;
  int   checks;

  logic [7:0]  ram [0:4095];
  logic        pre_we;
  logic [11:0] pre_addr;
  logic [7:0]  pre_data;

  mem_ctrl_if #(.ADDR_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model: synchronous write, registered read, plus a bench-only preload port
  always @(posedge clock) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (bus.ram_wr) ram[bus.ram_addr[11:0]] <= bus.ram_dout;
    bus.ram_din <= ram[bus.ram_addr[11:0]];
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0]  st_bytes [4];
    errors = 0;
    checks = 0;
    reset = 1'b1;
    pre_we = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.mem_req = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_size = 2'b00;
    bus.mem_addr = '0;
    bus.mem_wdata = '0;
    step();

    // Preload fetch word at 0x40 and guard bytes at 0x202/0x203
    for (int i = 0; i < 6; i++) begin
      pre_we   = 1'b1;
      pre_addr = (i < 4) ? 12'(12'h040 + i) : 12'(12'h1FE + i);
      pre_data = (i < 4) ? 8'(8'h11 * (i + 1)) : 8'hAA;
      step();
    end
    pre_we = 1'b0;

    // Reset held with if_req high
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ram_wr", 32'(bus.ram_wr), 32'd0);
      chk("rst_ram_addr", bus.ram_addr, 32'd0);
      chk("rst_if_ready", 32'(bus.if_ready), 32'd0);
      chk("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
    end
    chk("rst_if_data", bus.if_data, 32'd0);
    chk("rst_mem_rdata", bus.mem_rdata, 32'd0);

    // First accept at the first edge after reset drops
    reset = 1'b0;
    step();
    chk("fetch0_c1_addr", bus.ram_addr, 32'h40);
    chk("fetch0_c1_stall", 32'(bus.stall_if), 32'd1);
    for (int k = 2; k <= 5; k++) begin
      step();
      chk("fetch0_addr", bus.ram_addr, (k <= 4) ? 32'(32'h40 + k - 1) : 32'd0);
      chk("fetch0_no_ready", 32'(bus.if_ready), 32'd0);
    end
    step();
    chk("fetch0_ready", 32'(bus.if_ready), 32'd1);
    chk("fetch0_data", bus.if_data, 32'h44332211);
    chk("fetch0_stall_off", 32'(bus.stall_if), 32'd0);
    bus.if_req = 1'b0;
    step();
    chk("fetch0_pulse_end", 32'(bus.if_ready), 32'd0);
    chk("fetch0_data_hold", bus.if_data, 32'h44332211);

    // Word store 0xDEADBEEF at 0x100; inputs scrambled after accept
    st_bytes[0] = 8'hEF; st_bytes[1] = 8'hBE; st_bytes[2] = 8'hAD; st_bytes[3] = 8'hDE;
    bus.mem_req = 1'b1;
    bus.mem_write = 1'b1;
    bus.mem_size = 2'b10;
    bus.mem_addr = 32'h100;
    bus.mem_wdata = 32'hDEADBEEF;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("st_wr", 32'(bus.ram_wr), 32'd1);
      chk("st_addr", bus.ram_addr, 32'(32'h100 + k - 1));
      chk("st_dout", 32'(bus.ram_dout), 32'(st_bytes[k-1]));
      chk("st_stall", 32'(bus.stall_mem), 32'd1);
      bus.mem_wdata = 32'h0;
      bus.mem_addr  = 32'h300;
    end
    step();
    chk("st_ready", 32'(bus.mem_ready), 32'd1);
    chk("st_done_wr", 32'(bus.ram_wr), 32'd0);
    chk("st_done_addr", bus.ram_addr, 32'd0);
    chk("st_stall_off", 32'(bus.stall_mem), 32'd0);
    bus.mem_req = 1'b0;
    step();
    chk("st_pulse_end", 32'(bus.mem_ready), 32'd0);

    // Fetch of the stored word
    bus.if_req = 1'b1;
    bus.if_addr = 32'h100;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("fetch1_stall", 32'(bus.stall_if), 32'd1);
    end
    step();
    chk("fetch1_ready", 32'(bus.if_ready), 32'd1);
    chk("fetch1_data", bus.if_data, 32'hDEADBEEF);
    bus.if_req = 1'b0;
    step();

    // Half load at 0x102
    bus.mem_req = 1'b1;
    bus.mem_write = 1'b0;
    bus.mem_size = 2'b01;
    bus.mem_addr = 32'h102;
    step(); step(); step();
    chk("ldh_c3_no_ready", 32'(bus.mem_ready), 32'd0);
    step();
    chk("ldh_ready", 32'(bus.mem_ready), 32'd1);
    chk("ldh_data", bus.mem_rdata, 32'h0000DEAD);
    bus.mem_req = 1'b0;
    step();

    // Byte load at 0x103
    bus.mem_req = 1'b1;
    bus.mem_size = 2'b00;
    bus.mem_addr = 32'h103;
    step(); step();
    chk("ldb_c2_no_ready", 32'(bus.mem_ready), 32'd0);
    step();
    chk("ldb_ready", 32'(bus.mem_ready), 32'd1);
    chk("ldb_data", bus.mem_rdata, 32'h000000DE);
    bus.mem_req = 1'b0;
    step();
    chk("ldb_data_hold", bus.mem_rdata, 32'h000000DE);

    // Size 11 behaves as word; address wraps past 0xFFFFFFFF
    bus.mem_req = 1'b1;
    bus.mem_size = 2'b11;
    bus.mem_addr = 32'hFFFFFFFE;
    step();
    chk("wrap_c1_addr", bus.ram_addr, 32'hFFFFFFFE);
    step(); step();
    chk("wrap_c3_addr", bus.ram_addr, 32'h00000000);
    step();
    chk("wrap_c4_addr", bus.ram_addr, 32'h00000001);
    step();
    chk("wrap_c5_no_ready", 32'(bus.mem_ready), 32'd0);
    step();
    chk("wrap_ready", 32'(bus.mem_ready), 32'd1);
    bus.mem_req = 1'b0;
    step();

    // Contention: MEM first, IF from the following IDLE, each served once
    bus.if_req = 1'b1;
    bus.if_addr = 32'h40;
    bus.mem_req = 1'b1;
    bus.mem_size = 2'b10;
    bus.mem_addr = 32'h100;
    step();
    chk("cont_mem_first", bus.ram_addr, 32'h100);
    chk("cont_stall_if", 32'(bus.stall_if), 32'd1);
    step(); step(); step(); step();
    chk("cont_c5_no_ready", 32'(bus.mem_ready), 32'd0);
    step();
    chk("cont_mem_ready", 32'(bus.mem_ready), 32'd1);
    chk("cont_mem_data", bus.mem_rdata, 32'hDEADBEEF);
    chk("cont_if_wait", 32'(bus.if_ready), 32'd0);
    bus.mem_req = 1'b0;
    step();
    chk("cont_idle_addr", bus.ram_addr, 32'd0);
    chk("cont_idle_mem_ready", 32'(bus.mem_ready), 32'd0);
    step();
    chk("cont_if_accept", bus.ram_addr, 32'h40);
    step(); step(); step(); step();
    chk("cont_if_c5", 32'(bus.if_ready), 32'd0);
    step();
    chk("cont_if_ready", 32'(bus.if_ready), 32'd1);
    chk("cont_if_data", bus.if_data, 32'h44332211);
    chk("cont_no_mem_again", 32'(bus.mem_ready), 32'd0);
    bus.if_req = 1'b0;
    step();
    chk("cont_if_once", 32'(bus.if_ready), 32'd0);
    step();
    chk("cont_quiet_addr", bus.ram_addr, 32'd0);

    // Reset during the second write cycle of a word store
    bus.mem_req = 1'b1;
    bus.mem_write = 1'b1;
    bus.mem_size = 2'b10;
    bus.mem_addr = 32'h200;
    bus.mem_wdata = 32'h11223344;
    step();
    chk("rw_c1_addr", bus.ram_addr, 32'h200);
    step();
    chk("rw_c2_wr", 32'(bus.ram_wr), 32'd1);
    chk("rw_c2_dout", 32'(bus.ram_dout), 32'h33);
    reset = 1'b1;
    step();
    chk("rw_wr_off", 32'(bus.ram_wr), 32'd0);
    chk("rw_addr_zero", bus.ram_addr, 32'd0);
    chk("rw_no_ready", 32'(bus.mem_ready), 32'd0);
    reset = 1'b0;
    bus.mem_req = 1'b0;
    bus.mem_write = 1'b0;
    step();
    chk("rw_no_ready2", 32'(bus.mem_ready), 32'd0);
    chk("rw_mem200", 32'(ram[12'h200]), 32'h44);
    chk("rw_mem201", 32'(ram[12'h201]), 32'h33);
    chk("rw_mem202", 32'(ram[12'h202]), 32'hAA);
    chk("rw_mem203", 32'(ram[12'h203]), 32'hAA);

    // Back in IDLE: byte load of a partially written byte
    bus.mem_req = 1'b1;
    bus.mem_size = 2'b00;
    bus.mem_addr = 32'h201;
    step();
    chk("rw_ld_addr", bus.ram_addr, 32'h201);
    step(); step();
    chk("rw_ld_ready", 32'(bus.mem_ready), 32'd1);
    chk("rw_ld_data", bus.mem_rdata, 32'h00000033);
    bus.mem_req = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
